// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
//
// Purpose:
//   Writer-side counterpart of the instruction ROM. Receives a program as a
//   byte stream, assembles bytes little-endian into 32-bit words and writes
//   them into a writable program memory. Byte addresses start at
//   BASE_ADDRESS and step by 4. The core is held in reset while a load is
//   in progress, and a one-cycle Done_o pulse marks the end of a load.
//
// Ports:
//   clk              in   system clock, rising edge
//   reset            in   synchronous, active-high reset
//   Start_i          in   one-cycle load request, honoured only in IDLE
//   Word_Count_i     in   number of words to load (clamped to MEMORY_DEPTH)
//   Byte_i           in   incoming program byte
//   Byte_Valid_i     in   Byte_i is valid
//   Byte_Ready_o     out  loader accepts a byte this cycle
//   Mem_Write_o      out  write strobe to program memory
//   Mem_Address_o    out  byte address of the word being written
//   Mem_Data_o       out  assembled instruction word
//   Busy_o           out  load in progress
//   Cpu_Reset_o      out  holds the core in reset while busy
//   Checksum_Error_o out  (checksum build only) checksum byte did not match
//   Done_o           out  one-cycle pulse at the end of a load
//
// Build option:
//   PROGRAM_LOADER_CHECKSUM_EN - when defined, a CHECK state follows the
//   last word and consumes one checksum byte C. Checksum_Error_o is raised
//   if (sum of all data bytes + C) mod 256 != 0.
// ---------------------------------------------------------------------------
module program_loader #(
  parameter int          DATA_WIDTH   = 32,
  parameter int          MEMORY_DEPTH = 32,
  parameter logic [31:0] BASE_ADDRESS = 32'h0040_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Start_i,
  input  logic [15:0]           Word_Count_i,
  input  logic [7:0]            Byte_i,
  input  logic                  Byte_Valid_i,
  output logic                  Byte_Ready_o,
  output logic                  Mem_Write_o,
  output logic [31:0]           Mem_Address_o,
  output logic [DATA_WIDTH-1:0] Mem_Data_o,
  output logic                  Busy_o,
  output logic                  Cpu_Reset_o,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  output logic                  Checksum_Error_o,
`endif
  output logic                  Done_o
);

  // Word counter sized so that MEMORY_DEPTH itself is representable.
  localparam int              CW       = $clog2(MEMORY_DEPTH + 1);
  localparam logic [15:0]     DEPTH16  = 16'(MEMORY_DEPTH);
  localparam logic [CW-1:0]   DEPTH_CW = CW'(MEMORY_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    RECEIVE,
    WRITE,
    DONE
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    ,
    CHECK
`endif
  } state_t;

  state_t                state;
  state_t                next_state;

  logic [1:0]            byte_idx;
  logic [CW-1:0]         word_idx;
  logic [CW-1:0]         num_words;
  logic [CW-1:0]         clamped_count;
  logic [31:0]           addr_reg;
  logic [DATA_WIDTH-1:0] data_reg;
  logic [DATA_WIDTH-1:0] data_next;
  logic [31:0]           mem_addr_reg;
  logic [DATA_WIDTH-1:0] mem_data_reg;
  logic                  busy_reg;

  logic                  handshake;
  logic                  start_accept;
  logic                  last_byte;
  logic                  last_word;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]            sum;
  logic                  checksum_error;
`endif

  // Handshake and decode helpers. Ready comes purely from state, so the
  // handshake is valid AND ready with no path from valid back to ready.
  assign handshake     = Byte_Valid_i & Byte_Ready_o;
  assign start_accept  = (state == IDLE) & Start_i;
  assign last_byte     = handshake & (state == RECEIVE) & (byte_idx == 2'd3);
  assign last_word     = ((word_idx + CW'(1)) == num_words);
  assign clamped_count = (Word_Count_i > DEPTH16) ? DEPTH_CW : Word_Count_i[CW-1:0];

  // Insert the incoming byte into its little-endian lane of the word being
  // assembled; this is also the word captured on the fourth byte.
  always_comb begin
    data_next = data_reg;
    data_next[{byte_idx, 3'b000} +: 8] = Byte_i;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and state-decoded strobes.
  always_comb begin
    next_state   = state;
    Byte_Ready_o = 1'b0;
    Mem_Write_o  = 1'b0;
    Done_o       = 1'b0;
    unique case (state)
      IDLE: begin
        if (Start_i) begin
          if (clamped_count == '0) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            next_state = CHECK;
`else
            next_state = DONE;
`endif
          end else begin
            next_state = RECEIVE;
          end
        end
      end
      RECEIVE: begin
        Byte_Ready_o = 1'b1;
        if (last_byte) begin
          next_state = WRITE;
        end
      end
      WRITE: begin
        Mem_Write_o = 1'b1;
        if (last_word) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          next_state = CHECK;
`else
          next_state = DONE;
`endif
        end else begin
          next_state = RECEIVE;
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      CHECK: begin
        Byte_Ready_o = 1'b1;
        if (handshake) begin
          next_state = DONE;
        end
      end
`endif
      DONE: begin
        Done_o     = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Datapath. The memory address/data outputs are separate registers so
  // they read 0 out of reset and hold the last written word between writes,
  // while addr_reg already points at the next word. Busy is registered from
  // next_state so Busy_o/Cpu_Reset_o come straight from a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_idx     <= 2'd0;
      word_idx     <= '0;
      num_words    <= '0;
      addr_reg     <= BASE_ADDRESS;
      data_reg     <= '0;
      mem_addr_reg <= '0;
      mem_data_reg <= '0;
      busy_reg     <= 1'b0;
    end else begin
      busy_reg <= (next_state != IDLE);

      if (start_accept) begin
        num_words <= clamped_count;
        word_idx  <= '0;
        addr_reg  <= BASE_ADDRESS;
        byte_idx  <= 2'd0;
      end

      if ((state == RECEIVE) && handshake) begin
        data_reg <= data_next;
        byte_idx <= byte_idx + 2'd1;
        if (byte_idx == 2'd3) begin
          mem_addr_reg <= addr_reg;
          mem_data_reg <= data_next;
        end
      end

      if (state == WRITE) begin
        word_idx <= word_idx + CW'(1);
        addr_reg <= addr_reg + 32'd4;
        byte_idx <= 2'd0;
      end
    end
  end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  // Running mod-256 sum of data bytes and the sticky error flag. Both are
  // cleared when a new load is accepted so each load is judged on its own.
  always_ff @(posedge clk) begin
    if (reset) begin
      sum            <= 8'd0;
      checksum_error <= 1'b0;
    end else begin
      if (start_accept) begin
        sum            <= 8'd0;
        checksum_error <= 1'b0;
      end
      if ((state == RECEIVE) && handshake) begin
        sum <= sum + Byte_i;
      end
      if ((state == CHECK) && handshake) begin
        checksum_error <= ((sum + Byte_i) != 8'd0);
      end
    end
  end

  assign Checksum_Error_o = checksum_error;
`endif

  assign Mem_Address_o = mem_addr_reg;
  assign Mem_Data_o    = mem_data_reg;
  assign Busy_o        = busy_reg;
  assign Cpu_Reset_o   = busy_reg;

endmodule

// File: tb/tb_program_loader.sv
// ---------------------------------------------------------------------------
// tb_program_loader
//
// Self-checking bench for program_loader. A table of load records plus
// randomized loads are driven through the byte stream; expected words and
// addresses come from a simple byte-list model (word i = bytes 4i..4i+3,
// little-endian, at BASE + 4i). Hand-written sequences cover stalls,
// zero-length loads, reset mid-load and ignored Start pulses.
// ---------------------------------------------------------------------------
module tb_program_loader;

  localparam int          DEPTH = 32;
  localparam logic [31:0] BASE  = 32'h0040_0000;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam int          CK_BYTES = 1;
`else
  localparam int          CK_BYTES = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] word_count;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_data;
  logic        busy;
  logic        cpu_reset;
  logic        done;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic        checksum_error;
`endif

  typedef struct {
    int          word_count;
    int          stall_max;
    int          exp_writes;
    logic [31:0] exp_last;
  } load_vec_t;

  int          checks     = 0;
  int          errors     = 0;
  int          done_count = 0;
  int          hs_count   = 0;
  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];

  program_loader #(
    .DATA_WIDTH  (32),
    .MEMORY_DEPTH(DEPTH),
    .BASE_ADDRESS(BASE)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .Start_i         (start),
    .Word_Count_i    (word_count),
    .Byte_i          (byte_data),
    .Byte_Valid_i    (byte_valid),
    .Byte_Ready_o    (byte_ready),
    .Mem_Write_o     (mem_write),
    .Mem_Address_o   (mem_address),
    .Mem_Data_o      (mem_data),
    .Busy_o          (busy),
    .Cpu_Reset_o     (cpu_reset),
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    .Checksum_Error_o(checksum_error),
`endif
    .Done_o          (done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Observe the bus mid-cycle: log writes, Done pulses and byte handshakes.
  always @(negedge clk) begin
    if (mem_write === 1'b1) begin
      got_addr.push_back(mem_address);
      got_data.push_back(mem_data);
      checkOutput("ready_low_in_write", 32'(byte_ready), 32'd0);
    end
    if (done === 1'b1) done_count++;
    if (byte_valid === 1'b1 && byte_ready === 1'b1) hs_count++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulseStart(input int wc);
    start      = 1'b1;
    word_count = 16'(wc);
    tick;
    start      = 1'b0;
  endtask

  // Present one byte and hold it until it has been accepted.
  task automatic sendByte(input logic [7:0] b, input int stall_max);
    int n;
    int idle;
    idle = (stall_max > 0) ? int'($urandom_range(stall_max, 0)) : 0;
    repeat (idle) tick;
    byte_data  = b;
    byte_valid = 1'b1;
    n = 0;
    while (byte_ready !== 1'b1 && n < 100) begin
      tick;
      n++;
    end
    if (byte_ready !== 1'b1) checkOutput("byte_ready_timeout", 32'(byte_ready), 32'd1);
    else tick;
    byte_valid = 1'b0;
  endtask

  // Wait for Done_o, then confirm Busy/Cpu_Reset drop on the following cycle.
  task automatic waitDone(input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      tick;
      n++;
    end
    if (done !== 1'b1) begin
      checkOutput({name, "_done_timeout"}, 32'(done), 32'd1);
    end else begin
      checkOutput({name, "_busy_at_done"}, 32'(busy), 32'd1);
      checkOutput({name, "_cpurst_at_done"}, 32'(cpu_reset), 32'd1);
      tick;
      checkOutput({name, "_busy_after_done"}, 32'(busy), 32'd0);
      checkOutput({name, "_cpurst_after_done"}, 32'(cpu_reset), 32'd0);
    end
  endtask

  task automatic clearLog;
    got_addr.delete();
    got_data.delete();
  endtask

  // Run one complete load with random data and compare against the model.
  task automatic applyStimulus(input load_vec_t v);
    logic [7:0]  bytes[$];
    logic [7:0]  sum;
    logic [7:0]  c;
    logic [31:0] w;
    int          n;
    int          d0;
    int          h0;
    clearLog();
    d0  = done_count;
    h0  = hs_count;
    n   = (v.word_count > DEPTH) ? DEPTH : v.word_count;
    sum = 8'd0;
    c   = 8'd0;
    for (int i = 0; i < 4 * n; i++) begin
      bytes.push_back(8'($urandom));
      sum = sum + bytes[i];
    end
    pulseStart(v.word_count);
    for (int i = 0; i < 4 * n; i++) sendByte(bytes[i], v.stall_max);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    c = ($urandom_range(1, 0) == 1) ? 8'(8'd0 - sum) : 8'($urandom);
    sendByte(c, v.stall_max);
`endif
    waitDone("load");
    tick;
    checkOutput("write_count", 32'(got_addr.size()), 32'(v.exp_writes));
    for (int i = 0; i < n && i < got_addr.size(); i++) begin
      w = {bytes[4*i+3], bytes[4*i+2], bytes[4*i+1], bytes[4*i]};
      checkOutput("write_addr", got_addr[i], BASE + 32'(4 * i));
      checkOutput("write_data", got_data[i], w);
    end
    if (v.exp_writes > 0 && got_addr.size() > 0)
      checkOutput("last_addr", got_addr[got_addr.size()-1], v.exp_last);
    checkOutput("done_pulses", 32'(done_count - d0), 32'd1);
    checkOutput("byte_handshakes", 32'(hs_count - h0), 32'(4 * n + CK_BYTES));
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    checkOutput("checksum_error", 32'(checksum_error), 32'((sum + c) != 8'd0));
`endif
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    load_vec_t   vecs[8];
    load_vec_t   rv;
    logic [7:0]  tp_bytes[8];
    int          d0;
    int          h0;
    int          wc;
    int          nw;

    vecs[0] = '{1,     0, 1,  32'h0040_0000};
    vecs[1] = '{2,     2, 2,  32'h0040_0004};
    vecs[2] = '{0,     0, 0,  32'h0000_0000};
    vecs[3] = '{5,     1, 5,  32'h0040_0010};
    vecs[4] = '{40,    0, 32, 32'h0040_007C};
    vecs[5] = '{32,    1, 32, 32'h0040_007C};
    vecs[6] = '{33,    0, 32, 32'h0040_007C};
    vecs[7] = '{65535, 0, 32, 32'h0040_007C};
    tp_bytes = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h02, 8'h10, 8'h00};

    reset      = 1'b1;
    start      = 1'b0;
    word_count = 16'd0;
    byte_data  = 8'd0;
    byte_valid = 1'b0;
    repeat (3) tick;

    // Reset values.
    checkOutput("rst_ready",   32'(byte_ready), 32'd0);
    checkOutput("rst_write",   32'(mem_write),  32'd0);
    checkOutput("rst_addr",    mem_address,     32'd0);
    checkOutput("rst_data",    mem_data,        32'd0);
    checkOutput("rst_busy",    32'(busy),       32'd0);
    checkOutput("rst_cpurst",  32'(cpu_reset),  32'd0);
    checkOutput("rst_done",    32'(done),       32'd0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    checkOutput("rst_chkerr",  32'(checksum_error), 32'd0);
`endif
    reset = 1'b0;
    tick;

    // Reference two-word program.
    clearLog();
    d0 = done_count;
    pulseStart(2);
    checkOutput("tp_ready_in_receive", 32'(byte_ready), 32'd1);
    for (int i = 0; i < 8; i++) sendByte(tp_bytes[i], 0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    sendByte(8'h43, 0);
`endif
    waitDone("tp");
    tick;
    checkOutput("tp_writes", 32'(got_addr.size()), 32'd2);
    if (got_addr.size() == 2) begin
      checkOutput("tp_addr0", got_addr[0], 32'h0040_0000);
      checkOutput("tp_data0", got_data[0], 32'h0000_0513);
      checkOutput("tp_addr1", got_addr[1], 32'h0040_0004);
      checkOutput("tp_data1", got_data[1], 32'h0010_0293);
    end
    checkOutput("tp_done_pulses", 32'(done_count - d0), 32'd1);
    checkOutput("tp_addr_hold", mem_address, 32'h0040_0004);
    checkOutput("tp_data_hold", mem_data, 32'h0010_0293);

    // Stall between bytes 2 and 3.
    clearLog();
    h0 = hs_count;
    pulseStart(1);
    sendByte(8'h13, 0);
    sendByte(8'h05, 0);
    repeat (5) tick;
    checkOutput("stall_ready", 32'(byte_ready), 32'd1);
    sendByte(8'h00, 0);
    sendByte(8'h00, 0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    sendByte(8'hE8, 0);
`endif
    waitDone("stall");
    tick;
    checkOutput("stall_writes", 32'(got_addr.size()), 32'd1);
    if (got_addr.size() == 1) checkOutput("stall_data", got_data[0], 32'h0000_0513);
    checkOutput("stall_handshakes", 32'(hs_count - h0), 32'(4 + CK_BYTES));

    // Zero-length load.
    clearLog();
    d0 = done_count;
    pulseStart(0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    checkOutput("zero_check_ready", 32'(byte_ready), 32'd1);
    sendByte(8'h00, 0);
`endif
    checkOutput("zero_done_now", 32'(done), 32'd1);
    tick;
    tick;
    checkOutput("zero_busy_after", 32'(busy), 32'd0);
    checkOutput("zero_writes", 32'(got_addr.size()), 32'd0);
    checkOutput("zero_done_pulses", 32'(done_count - d0), 32'd1);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    checkOutput("zero_chkerr", 32'(checksum_error), 32'd0);
`endif

    // Reset after 6 bytes of a 2-word load.
    clearLog();
    d0 = done_count;
    pulseStart(2);
    for (int i = 0; i < 6; i++) sendByte(8'(8'h11 + i), 0);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    checkOutput("midrst_busy",   32'(busy),       32'd0);
    checkOutput("midrst_ready",  32'(byte_ready), 32'd0);
    checkOutput("midrst_cpurst", 32'(cpu_reset),  32'd0);
    repeat (3) tick;
    checkOutput("midrst_writes", 32'(got_addr.size()), 32'd1);
    if (got_addr.size() == 1) checkOutput("midrst_data0", got_data[0], 32'h1413_1211);
    checkOutput("midrst_no_done", 32'(done_count - d0), 32'd0);
    applyStimulus('{1, 0, 1, 32'h0040_0000});

    // Start pulsed during RECEIVE is ignored.
    clearLog();
    pulseStart(2);
    sendByte(8'h00, 0);
    sendByte(8'h00, 0);
    pulseStart(5);
    for (int i = 0; i < 6 + CK_BYTES; i++) sendByte(8'h00, 0);
    waitDone("ign");
    tick;
    checkOutput("ign_writes", 32'(got_addr.size()), 32'd2);
    if (got_addr.size() == 2) checkOutput("ign_addr1", got_addr[1], 32'h0040_0004);
    checkOutput("ign_idle", 32'(busy), 32'd0);

    // Reset and Start in the same cycle: reset wins.
    reset = 1'b1;
    start = 1'b1;
    word_count = 16'd3;
    tick;
    reset = 1'b0;
    start = 1'b0;
    checkOutput("rststart_busy", 32'(busy), 32'd0);
    tick;
    checkOutput("rststart_ready", 32'(byte_ready), 32'd0);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // Checksum good, then bad, then cleared by an accepted Start.
    pulseStart(1);
    sendByte(8'hFF, 0); sendByte(8'h00, 0); sendByte(8'h00, 0); sendByte(8'h00, 0);
    sendByte(8'h01, 0);
    waitDone("ck_good");
    checkOutput("ck_good_err", 32'(checksum_error), 32'd0);
    pulseStart(1);
    sendByte(8'hFF, 0); sendByte(8'h00, 0); sendByte(8'h00, 0); sendByte(8'h00, 0);
    sendByte(8'h00, 0);
    waitDone("ck_bad");
    checkOutput("ck_bad_err", 32'(checksum_error), 32'd1);
    pulseStart(1);
    checkOutput("ck_cleared", 32'(checksum_error), 32'd0);
    sendByte(8'hFF, 0); sendByte(8'h00, 0); sendByte(8'h00, 0); sendByte(8'h00, 0);
    sendByte(8'h01, 0);
    waitDone("ck_restart");
`endif

    // Table-driven loads.
    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

    // Randomized loads.
    for (int i = 0; i < 6; i++) begin
      wc = int'($urandom_range(40, 0));
      nw = (wc > DEPTH) ? DEPTH : wc;
      rv = '{wc, int'($urandom_range(3, 0)), nw,
             (nw > 0) ? BASE + 32'(4 * (nw - 1)) : 32'd0};
      applyStimulus(rv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
